// File: rtl/raizing_pkg.sv
// Shared definitions for the 93C46 serial EEPROM: geometry, FSM states,
// opcode and extended-command encodings.
package raizing_pkg;

  localparam int EE_WORDS = 64;
  localparam int EE_AW    = 6;
  localparam int EE_DW    = 16;

  localparam logic [EE_DW-1:0] ERASE_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_READ,
    ST_WDATA,
    ST_PROG,
    ST_DONE
  } ee_state_t;

  // Two opcode bits following the start bit
  typedef enum logic [1:0] {
    OP_EXT   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_ERASE = 2'b11
  } ee_op_t;

  // Address bits [5:4] select the variant of opcode 00
  typedef enum logic [1:0] {
    EXT_EWDS = 2'b00,
    EXT_WRAL = 2'b01,
    EXT_ERAL = 2'b10,
    EXT_EWEN = 2'b11
  } ee_ext_t;

  // Array operation pending execution when chip select falls in DONE
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_WRITE,
    CMD_ERASE,
    CMD_ERAL,
    CMD_WRAL
  } ee_cmd_t;

  function automatic logic is_bulk(input ee_cmd_t c);
    return (c == CMD_ERAL) || (c == CMD_WRAL);
  endfunction

endpackage

// File: rtl/raizing_eeprom_ram.sv
// 64x16 dual-port storage array. Port A is the serial command side, port B
// the host save/load side. Both ports read synchronously; a host write that
// collides with a serial write to the same word is dropped.
module raizing_eeprom_ram
  import raizing_pkg::*;
#(
  parameter logic [EE_DW-1:0] INIT_FILL = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [EE_AW-1:0] a_addr,
  input  logic [EE_DW-1:0] a_din,
  input  logic             a_we,
  output logic [EE_DW-1:0] a_dout,
  input  logic [EE_AW-1:0] b_addr,
  input  logic [EE_DW-1:0] b_din,
  input  logic             b_we,
  output logic [EE_DW-1:0] b_dout
);

  // Contents survive reset; only the power-up fill sets them initially.
  logic [EE_DW-1:0] mem [EE_WORDS] = '{default: INIT_FILL};

  logic b_blocked;
  assign b_blocked = a_we && (a_addr == b_addr);

  // Array writes: serial side always, host side unless it hits the same word
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_din;
    end
    if (b_we && !b_blocked) begin
      mem[b_addr] <= b_din;
    end
  end

  // Registered read ports; read-during-write returns the old word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/raizing_eeprom_93c46.sv
// 93C46-compatible serial EEPROM (x16 organisation) as wired to the 68K I/O
// latch, with a host-side port for NVRAM save/load.
module raizing_eeprom_93c46
  import raizing_pkg::*;
#(
  parameter int               WR_BUSY   = 64,
  parameter logic [EE_DW-1:0] INIT_FILL = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SCS,
  input  logic             SCLK,
  input  logic             SDI,
  output logic             SDO,
  input  logic [EE_AW-1:0] DUMP_ADDR,
  input  logic [EE_DW-1:0] DUMP_DIN,
  input  logic             DUMP_WE,
  output logic [EE_DW-1:0] DUMP_DOUT,
  output logic             BUSY
);

  // Bulk writes need one cycle per word, so they never finish before 64.
  localparam int          BULK_CYCLES = (WR_BUSY > EE_WORDS) ? WR_BUSY : EE_WORDS;
  localparam logic [15:0] PROG_LAST   = 16'(WR_BUSY - 1);
  localparam logic [15:0] BULK_LAST   = 16'(BULK_CYCLES - 1);

  ee_state_t        state, state_n;
  ee_op_t           op, op_n;
  ee_cmd_t          cmd, cmd_n;
  logic [EE_AW-1:0] addr, addr_n;
  logic [EE_DW-1:0] data, data_n;
  logic [EE_DW-1:0] rd_sh, rd_sh_n;
  logic [3:0]       cnt, cnt_n;
  logic [15:0]      prog_cnt, prog_n;
  logic             wen, wen_n;
  logic             rd_bit, rd_bit_n;
  logic             load_pend, load_n;
  logic             sclk_q;
  logic             sclk_rise;

  logic [EE_AW-1:0] a_addr;
  logic [EE_DW-1:0] a_din;
  logic [EE_DW-1:0] a_dout;
  logic             a_we;

  raizing_eeprom_ram #(
    .INIT_FILL (INIT_FILL)
  ) u_ram (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .a_addr (a_addr),
    .a_din  (a_din),
    .a_we   (a_we),
    .a_dout (a_dout),
    .b_addr (DUMP_ADDR),
    .b_din  (DUMP_DIN),
    .b_we   (DUMP_WE),
    .b_dout (DUMP_DOUT)
  );

  assign sclk_rise = SCLK && !sclk_q;
  assign BUSY      = (state == ST_PROG);

  // Ready/busy and read data share the SDO pin; deselected reads as 1.
  assign SDO = !SCS ? 1'b1 :
               BUSY ? 1'b0 :
               (state == ST_READ) ? rd_bit : 1'b1;

  // State register plus all command datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      op        <= OP_EXT;
      cmd       <= CMD_NONE;
      addr      <= '0;
      data      <= '0;
      rd_sh     <= '0;
      cnt       <= '0;
      prog_cnt  <= '0;
      wen       <= 1'b0;
      rd_bit    <= 1'b0;
      load_pend <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      cmd       <= cmd_n;
      addr      <= addr_n;
      data      <= data_n;
      rd_sh     <= rd_sh_n;
      cnt       <= cnt_n;
      prog_cnt  <= prog_n;
      wen       <= wen_n;
      rd_bit    <= rd_bit_n;
      load_pend <= load_n;
      sclk_q    <= SCLK;
    end
  end

  // Next-state, serial shifting and port-A array access
  always_comb begin
    state_n  = state;
    op_n     = op;
    cmd_n    = cmd;
    addr_n   = addr;
    data_n   = data;
    rd_sh_n  = rd_sh;
    cnt_n    = cnt;
    prog_n   = prog_cnt;
    wen_n    = wen;
    rd_bit_n = rd_bit;
    load_n   = 1'b0;
    a_addr   = addr;
    a_din    = data;
    a_we     = 1'b0;

    // A read issued last cycle has its word on a_dout now; SCLK edges are
    // at least two cycles apart so it is loaded before the next shift.
    if (load_pend) begin
      rd_sh_n = a_dout;
    end

    case (state)
      ST_IDLE: begin
        if (SCS && sclk_rise && SDI) begin
          state_n = ST_OPCODE;
          cnt_n   = '0;
        end
      end

      ST_OPCODE: begin
        if (!SCS) begin
          state_n = ST_IDLE;
        end else if (sclk_rise) begin
          op_n  = ee_op_t'({op[0], SDI});
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd1) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
          end
        end
      end

      ST_ADDR: begin
        if (!SCS) begin
          state_n = ST_IDLE;
        end else if (sclk_rise) begin
          addr_n = {addr[EE_AW-2:0], SDI};
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd5) begin
            cnt_n = '0;
            case (op)
              OP_READ: begin
                state_n  = ST_READ;
                rd_bit_n = 1'b0;
                a_addr   = addr_n;
                load_n   = 1'b1;
              end
              OP_WRITE: begin
                cmd_n   = CMD_WRITE;
                state_n = ST_WDATA;
              end
              OP_ERASE: begin
                cmd_n   = CMD_ERASE;
                state_n = ST_DONE;
              end
              default: begin
                case (ee_ext_t'(addr_n[EE_AW-1:EE_AW-2]))
                  EXT_EWEN: begin
                    wen_n   = 1'b1;
                    cmd_n   = CMD_NONE;
                    state_n = ST_DONE;
                  end
                  EXT_EWDS: begin
                    wen_n   = 1'b0;
                    cmd_n   = CMD_NONE;
                    state_n = ST_DONE;
                  end
                  EXT_ERAL: begin
                    cmd_n   = CMD_ERAL;
                    state_n = ST_DONE;
                  end
                  default: begin
                    cmd_n   = CMD_WRAL;
                    state_n = ST_WDATA;
                  end
                endcase
              end
            endcase
          end
        end
      end

      ST_READ: begin
        if (!SCS) begin
          state_n = ST_IDLE;
        end else if (sclk_rise) begin
          rd_bit_n = rd_sh[EE_DW-1];
          rd_sh_n  = {rd_sh[EE_DW-2:0], 1'b0};
          cnt_n    = cnt + 4'd1;
          if (cnt == 4'd15) begin
            // Sequential read: fetch the next word, wrapping 63 -> 0
            cnt_n  = '0;
            addr_n = addr + 6'd1;
            a_addr = addr_n;
            load_n = 1'b1;
          end
        end
      end

      ST_WDATA: begin
        if (!SCS) begin
          state_n = ST_IDLE;
        end else if (sclk_rise) begin
          data_n = {data[EE_DW-2:0], SDI};
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd15) begin
            cnt_n   = '0;
            state_n = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!SCS) begin
          if (wen && (cmd != CMD_NONE)) begin
            state_n = ST_PROG;
            prog_n  = '0;
            case (cmd)
              CMD_WRITE: begin
                a_we  = 1'b1;
                a_din = data;
              end
              CMD_ERASE: begin
                a_we  = 1'b1;
                a_din = ERASE_WORD;
              end
              CMD_ERAL: data_n = ERASE_WORD;
              default: ;
            endcase
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_PROG: begin
        prog_n = prog_cnt + 16'd1;
        if (is_bulk(cmd) && (prog_cnt < 16'(EE_WORDS))) begin
          a_we   = 1'b1;
          a_addr = prog_cnt[EE_AW-1:0];
          a_din  = data;
        end
        if (prog_cnt == (is_bulk(cmd) ? BULK_LAST : PROG_LAST)) begin
          state_n = ST_IDLE;
          prog_n  = '0;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_raizing_eeprom_93c46.sv
// Scoreboard bench for raizing_eeprom_93c46: serial commands and host-port
// traffic update an array model; expected outputs are queued and a monitor
// compares them against the DUT on the falling clock edge.
module tb_raizing_eeprom_93c46;

  localparam int K_SDO  = 0;
  localparam int K_BUSY = 1;
  localparam int K_DOUT = 2;

  localparam int WR_BUSY_T = 64;
  localparam int BULK_T    = 64;

  logic        clk;
  logic        reset_n;
  logic        scs;
  logic        sclk;
  logic        sdi;
  logic        sdo;
  logic [5:0]  dump_addr;
  logic [15:0] dump_din;
  logic        dump_we;
  logic [15:0] dump_dout;
  logic        busy;

  raizing_eeprom_93c46 dut (
    .CLK       (clk),
    .RESET_N   (reset_n),
    .SCS       (scs),
    .SCLK      (sclk),
    .SDI       (sdi),
    .SDO       (sdo),
    .DUMP_ADDR (dump_addr),
    .DUMP_DIN  (dump_din),
    .DUMP_WE   (dump_we),
    .DUMP_DOUT (dump_dout),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          req_cnt = 0;
  int          seen    = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  // Reference model: array contents and the write-enable latch
  logic [15:0] mem_m [64];
  bit          wen_m;

  task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
    sbq.push_back('{kind, exp, name});
    req_cnt++;
  endtask

  exp_t        mon_e;
  logic [15:0] mon_act;

  always @(negedge clk) begin
    while (seen != req_cnt) begin
      mon_e = sbq.pop_front();
      seen++;
      case (mon_e.kind)
        K_SDO:   mon_act = {15'd0, sdo};
        K_BUSY:  mon_act = {15'd0, busy};
        default: mon_act = dump_dout;
      endcase
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", mon_e.name, mon_act, mon_e.exp, $time);
      end
    end
  end

  task automatic clk_bit(input logic b);
    sdi  = b;
    sclk = 1'b0;
    @(posedge clk); #1;
    sclk = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [5:0] a);
    scs = 1'b1;
    expect_val(K_SDO, 16'd1, "sdo_ready");
    clk_bit(1'b1);
    clk_bit(op[1]);
    clk_bit(op[0]);
    for (int i = 5; i >= 0; i--) clk_bit(a[i]);
  endtask

  // Called one step after the edge where chip select low was seen in DONE
  task automatic expect_prog(input int n, input bit scs_hi);
    for (int i = 0; i < n; i++) begin
      scs  = scs_hi;
      sclk = ~sclk;
      sdi  = 1'b1;
      expect_val(K_BUSY, 16'd1, "busy_hi");
      expect_val(K_SDO, scs ? 16'd0 : 16'd1, "sdo_busy");
      @(posedge clk); #1;
    end
    scs  = 1'b0;
    sclk = 1'b0;
    sdi  = 1'b0;
    expect_val(K_BUSY, 16'd0, "busy_end");
    expect_val(K_SDO, 16'd1, "sdo_idle");
  endtask

  task automatic no_prog();
    expect_val(K_BUSY, 16'd0, "busy_lo");
    @(posedge clk); #1;
  endtask

  task automatic ser_write(input logic [5:0] a, input logic [15:0] d, input bit host_en,
                           input logic [5:0] ha, input logic [15:0] hd, input bit scs_hi);
    send_hdr(2'b01, a);
    for (int i = 15; i >= 0; i--) clk_bit(d[i]);
    scs = 1'b0;
    if (host_en) begin
      dump_addr = ha;
      dump_din  = hd;
      dump_we   = 1'b1;
    end
    @(posedge clk); #1;
    dump_we = 1'b0;
    if (wen_m) mem_m[a] = d;
    if (host_en && !(wen_m && ha == a)) mem_m[ha] = hd;
    if (wen_m) expect_prog(WR_BUSY_T, scs_hi);
    else no_prog();
  endtask

  task automatic ser_erase(input logic [5:0] a);
    send_hdr(2'b11, a);
    scs = 1'b0;
    @(posedge clk); #1;
    if (wen_m) begin
      mem_m[a] = 16'hFFFF;
      expect_prog(WR_BUSY_T, 1'b0);
    end else no_prog();
  endtask

  task automatic ser_ext(input logic [1:0] v);
    send_hdr(2'b00, {v, 4'b0000});
    scs = 1'b0;
    @(posedge clk); #1;
    if (v == 2'b11) wen_m = 1'b1;
    if (v == 2'b00) wen_m = 1'b0;
    no_prog();
  endtask

  task automatic ser_bulk(input bit wral, input logic [15:0] d);
    send_hdr(2'b00, wral ? 6'b010000 : 6'b100000);
    if (wral) for (int i = 15; i >= 0; i--) clk_bit(d[i]);
    scs = 1'b0;
    @(posedge clk); #1;
    if (wen_m) begin
      for (int k = 0; k < 64; k++) mem_m[k] = wral ? d : 16'hFFFF;
      expect_prog(BULK_T, 1'b0);
    end else no_prog();
  endtask

  task automatic ser_read(input logic [5:0] a, input int nwords);
    logic [5:0] ad;
    ad = a;
    send_hdr(2'b10, a);
    expect_val(K_SDO, 16'd0, "rd_dummy");
    for (int w = 0; w < nwords; w++) begin
      for (int b = 15; b >= 0; b--) begin
        clk_bit(1'($urandom_range(0, 1)));
        expect_val(K_SDO, {15'd0, mem_m[ad][b]}, "rd_bit");
      end
      ad = ad + 6'd1;
    end
    @(negedge clk); #1;
    scs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dump_rd(input logic [5:0] a);
    dump_addr = a;
    @(posedge clk); #1;
    expect_val(K_DOUT, mem_m[a], "dump_rd");
  endtask

  task automatic dump_wr(input logic [5:0] a, input logic [15:0] d);
    dump_addr = a;
    dump_din  = d;
    dump_we   = 1'b1;
    @(posedge clk); #1;
    dump_we  = 1'b0;
    mem_m[a] = d;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d9;
    logic [5:0]  ra, rb;
    logic [15:0] rd;
    int          sel;

    foreach (mem_m[i]) mem_m[i] = 16'hFFFF;
    wen_m     = 1'b0;
    reset_n   = 1'b0;
    scs       = 1'b0;
    sclk      = 1'b0;
    sdi       = 1'b0;
    dump_addr = '0;
    dump_din  = '0;
    dump_we   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_val(K_BUSY, 16'd0, "rst_busy");
    expect_val(K_SDO, 16'd1, "rst_sdo");
    expect_val(K_DOUT, 16'd0, "rst_dout");
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write without enable is ignored
    ser_write(6'd5, 16'h1234, 1'b0, 6'd0, 16'd0, 1'b0);
    dump_rd(6'd5);

    // Enabled write, busy with chip select held high, then read back
    ser_ext(2'b11);
    ser_write(6'd5, 16'hA55A, 1'b0, 6'd0, 16'd0, 1'b1);
    ser_read(6'd5, 1);
    dump_rd(6'd5);

    // Sequential read across the 63 -> 0 wrap
    ser_write(6'd63, 16'h1357, 1'b0, 6'd0, 16'd0, 1'b0);
    ser_write(6'd0, 16'h2468, 1'b0, 6'd0, 16'd0, 1'b0);
    ser_read(6'd63, 2);

    // Aborted write after 8 data bits
    send_hdr(2'b01, 6'd7);
    for (int i = 0; i < 8; i++) clk_bit(1'b1);
    scs = 1'b0;
    @(posedge clk); #1;
    no_prog();
    no_prog();
    dump_rd(6'd7);
    ser_write(6'd7, 16'h0F0F, 1'b0, 6'd0, 16'd0, 1'b0);
    dump_rd(6'd7);

    // Host write colliding with serial write, and to a different word
    ser_write(6'd10, 16'hBEEF, 1'b1, 6'd10, 16'h1111, 1'b0);
    dump_rd(6'd10);
    ser_write(6'd11, 16'hCAFE, 1'b1, 6'd12, 16'h2222, 1'b0);
    dump_rd(6'd11);
    dump_rd(6'd12);

    // Host write then immediate read-back
    dump_wr(6'd20, 16'h3C3C);
    dump_rd(6'd20);

    // Erase all
    ser_bulk(1'b0, 16'h0000);
    for (int k = 0; k < 64; k++) dump_rd(6'(k));

    // Write all, then disable and confirm writes are dropped
    ser_bulk(1'b1, 16'h5AA5);
    dump_rd(6'd0);
    dump_rd(6'd33);
    dump_rd(6'd63);
    ser_ext(2'b00);
    ser_write(6'd3, 16'h7777, 1'b0, 6'd0, 16'd0, 1'b0);
    ser_erase(6'd4);
    dump_rd(6'd3);
    dump_rd(6'd4);
    ser_ext(2'b11);

    // Randomized command mix
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 6);
      ra  = 6'($urandom);
      rb  = 6'($urandom);
      rd  = 16'($urandom);
      case (sel)
        0, 1: ser_write(ra, rd, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) == 1) ? ra : rb, 16'($urandom),
                        1'($urandom_range(0, 1)));
        2: ser_read(ra, $urandom_range(1, 2));
        3: begin
          dump_wr(ra, rd);
          dump_rd(ra);
        end
        4: ser_ext(($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11);
        5: ser_erase(ra);
        default: dump_rd(ra);
      endcase
    end

    // Reset in the middle of programming
    ser_ext(2'b11);
    d9 = 16'($urandom);
    send_hdr(2'b01, 6'd9);
    for (int i = 15; i >= 0; i--) clk_bit(d9[i]);
    scs = 1'b0;
    @(posedge clk); #1;
    mem_m[9] = d9;
    for (int i = 0; i < 3; i++) begin
      expect_val(K_BUSY, 16'd1, "busy_pre_rst");
      @(posedge clk); #1;
    end
    scs     = 1'b1;
    sclk    = 1'b0;
    sdi     = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    expect_val(K_BUSY, 16'd0, "midrst_busy");
    expect_val(K_SDO, 16'd1, "midrst_sdo");
    expect_val(K_DOUT, 16'd0, "midrst_dout");
    @(negedge clk); #1;
    reset_n = 1'b1;
    wen_m   = 1'b0;
    @(posedge clk); #1;
    ser_write(6'd9, ~d9, 1'b0, 6'd0, 16'd0, 1'b0);
    dump_rd(6'd9);

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/raizing_eeprom_93c46.md
RAIZING_EEPROM_93C46 -- requirements
Module: raizing_eeprom_93c46

Interface
REQ-001 Parameter WR_BUSY, default 64: number of CLK cycles the device reports busy after a programming command.
REQ-002 Parameter INIT_FILL, default 16'hFFFF: word value the array powers up with in simulation; RESET_N does not reload it.
REQ-003 CLK  in  1  48 MHz system clock; the only clock; all inputs are synchronous to it.
REQ-004 RESET_N  in  1  synchronous, active-low reset.
REQ-005 SCS  in  1  chip select from the 68K I/O latch, active high.
REQ-006 SCLK  in  1  serial clock from the 68K I/O latch; the block acts on its rising edge only.
REQ-007 SDI  in  1  serial data in, MSB first.
REQ-008 SDO  out  1  serial data out to the 68K input port.
REQ-009 DUMP_ADDR  in  6  word address for the host save/load (NVRAM) port.
REQ-010 DUMP_DIN  in  16  write data for the host port.
REQ-011 DUMP_WE  in  1  host-port write strobe, one word per asserted cycle.
REQ-012 DUMP_DOUT  out  16  host-port read data, registered, 1-cycle latency.
REQ-013 BUSY  out  1  high while a programming operation is in progress.

Function
REQ-014 Storage: 64 x 16-bit words, 6-bit word address. 93C46 command set in x16 mode.
REQ-015 SCLK rising-edge detect: SCLK high now and low on the previous CLK. Every edge action occurs in the same CLK cycle as the detection.
REQ-016 States: IDLE, OPCODE, ADDR, READ, WDATA, PROG, DONE.
REQ-017 IDLE: on an SCLK edge with SCS=1 and SDI=1 (start bit), go to OPCODE. SDI=0 edges are ignored.
REQ-018 OPCODE captures 2 bits. ADDR then captures 6 bits, MSB first. For opcode 00, address bits [5:4] select the variant: 11=EWEN, 00=EWDS, 10=ERAL, 01=WRAL.
REQ-019 READ (opcode 10):
- on the edge capturing address bit 0, SDO goes to 0 (dummy bit) in the following cycle;
- each later edge shifts out one data bit, MSB first;
- after bit 0 of a word, the address increments (63 wraps to 0) and streaming continues while SCS stays high.
REQ-020 WRITE (opcode 01) and WRAL: after the address, capture 16 data bits in WDATA, then wait in DONE for SCS to fall.
REQ-021 On SCS falling in DONE, the operation executes only if the write-enable latch is set:
- WRITE stores the data word at the address;
- ERASE (opcode 11) stores 16'hFFFF at the address;
- ERAL stores 16'hFFFF in all 64 words;
- WRAL stores the data word in all 64 words;
- then enter PROG.
If the latch is clear, return to IDLE with no change.
REQ-022 EWEN sets the write-enable latch and EWDS clears it, at the edge capturing the last address bit; the state then goes to DONE.
REQ-023 PROG holds BUSY=1 for WR_BUSY cycles. ERAL and WRAL update one word per cycle and hold BUSY for max(WR_BUSY, 64) cycles. The state then goes to IDLE.
REQ-024 While BUSY=1 and SCS=1, SDO=0; all SCLK edges are ignored.
REQ-025 When BUSY=0, SCS=1 and the state is not READ, SDO=1 (ready). SDO=1 whenever SCS=0.
REQ-026 SCS low in any state other than DONE or PROG aborts to IDLE with no array change. An incomplete WRITE does not write.
REQ-027 Host port:
- read is always allowed;
- a DUMP_WE write in the same cycle as a serial-side array write to the same word is dropped (serial side wins);
- a write to a different word proceeds.
REQ-028 A write takes effect at the next clock. DUMP_DOUT for an address written in the previous cycle returns the new value.

Reset
REQ-029 RESET_N=0 forces state IDLE, write-enable latch clear, BUSY=0, SDO=1, DUMP_DOUT=0, shift registers and counters 0.
REQ-030 Reset does not alter array contents. Reset during PROG abandons the remaining bulk-write words.

Structure
REQ-031 Opcode and state encodings go in the shared raizing package, together with constants EE_WORDS=64 and EE_AW=6.
REQ-032 Single sub-module raizing_eeprom_ram: 64x16 dual-port RAM, port A serial side, port B host side, each with synchronous read and write.

Verification
REQ-033 EWEN, WRITE addr 5 data 16'hA55A, then SCS low -> BUSY=1 for 64 cycles; a READ of addr 5 then returns 0, A,5,5,A on SDO.
REQ-034 Without EWEN after reset, WRITE addr 5 data 16'h1234 -> word 5 unchanged; DUMP_DOUT at addr 5 shows the prior value.
REQ-035 READ at addr 63 held for 32 data bits -> word 63 then word 0 are streamed.
REQ-036 EWEN, ERAL -> BUSY=1 for 64 cycles; every DUMP_DOUT afterwards = 16'hFFFF.
REQ-037 SCS dropped after 8 of 16 WRITE data bits -> no change, BUSY stays 0, the next start bit is accepted.
REQ-038 RESET_N=0 mid-PROG -> BUSY=0 and SDO=1 at the next cycle; the latch is clear, so a following WRITE is ignored.
